// File: rtl/proc_run_monitor.sv
// proc_run_monitor: run controller and checker for the single-cycle processor.
// On an accepted start it holds the core in reset, releases it, and watches
// the PC until it reaches the end address. After one settle cycle it captures
// dmemout and compares it with the expected value. A watchdog bounds the run
// length. Results and the RUN-cycle count are held until the next start.
module proc_run_monitor #(
    parameter int WIDTH        = 64,
    parameter int RESET_CYCLES = 1,
    parameter int WATCHDOG_MAX = 255
) (
    input  logic             CLK,
    input  logic             resetl,
    input  logic             start,
    input  logic [WIDTH-1:0] startpc_in,
    input  logic [WIDTH-1:0] endpc,
    input  logic [WIDTH-1:0] expected,
    input  logic [WIDTH-1:0] currentpc,
    input  logic [WIDTH-1:0] dmemout,
    output logic             proc_resetl,
    output logic [WIDTH-1:0] startpc,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [WIDTH-1:0] result,
    output logic [15:0]      cycles
);

    // Reset-hold counter only needs to count up to RESET_CYCLES-1.
    localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
    // The watchdog fires on the edge that takes cycles to WATCHDOG_MAX.
    localparam logic [15:0] WD_LAST = 16'(WATCHDOG_MAX - 1);

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        RUN,
        SETTLE,
        DONE
    } state_t;

    state_t           state_reg;
    logic [CW-1:0]    rst_cnt_reg;
    logic [WIDTH-1:0] endpc_reg;
    logic [WIDTH-1:0] expected_reg;

    // Run sequencer: every output is registered here, so the core sees a clean,
    // glitch-free reset and start address.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_reg    <= IDLE;
            rst_cnt_reg  <= '0;
            endpc_reg    <= '0;
            expected_reg <= '0;
            proc_resetl  <= 1'b0;
            startpc      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            result       <= '0;
            cycles       <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    // Between runs the core is left free-running and unmonitored.
                    proc_resetl <= 1'b1;
                    if (start) begin
                        startpc      <= startpc_in;
                        endpc_reg    <= endpc;
                        expected_reg <= expected;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        timeout      <= 1'b0;
                        result       <= '0;
                        cycles       <= '0;
                        busy         <= 1'b1;
                        rst_cnt_reg  <= '0;
                        proc_resetl  <= 1'b0;
                        state_reg    <= RESET;
                    end
                end

                RESET: begin
                    if (rst_cnt_reg == RST_LAST) begin
                        proc_resetl <= 1'b1;
                        state_reg   <= RUN;
                    end else begin
                        rst_cnt_reg <= rst_cnt_reg + 1'b1;
                    end
                end

                RUN: begin
                    if (cycles != 16'hFFFF) begin
                        cycles <= cycles + 16'd1;
                    end
                    // A PC hit on the same edge as the watchdog still counts as a hit.
                    if (currentpc >= endpc_reg) begin
                        state_reg <= SETTLE;
                    end else if (cycles == WD_LAST) begin
                        timeout   <= 1'b1;
                        pass      <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end

                SETTLE: begin
                    // dmemout now reflects the final load of the program.
                    result    <= dmemout;
                    pass      <= (dmemout == expected_reg);
                    timeout   <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state_reg <= DONE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proc_run_monitor.sv
// Testbench for proc_run_monitor: directed and randomized runs against a
// simple processor model, checked with a behavioural outcome model.
module tb_proc_run_monitor;

    localparam int W  = 64;
    localparam int WD = 255;

    logic          CLK = 1'b0;
    logic          resetl;
    logic          start;
    logic [W-1:0]  startpc_in, endpc, expected, dmemout;
    logic [W-1:0]  core_pc;
    logic [W-1:0]  pc_step;
    logic          proc_resetl, busy, done, pass, timeout;
    logic [W-1:0]  startpc, result;
    logic [15:0]   cycles;

    // Second build with a three-cycle reset hold; its PC sits at zero.
    logic          start3;
    logic [W-1:0]  zero_w;
    logic          proc_resetl3, busy3, done3, pass3, timeout3;
    logic [W-1:0]  startpc3, result3;
    logic [15:0]   cycles3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    proc_run_monitor #(.WIDTH(W), .RESET_CYCLES(1), .WATCHDOG_MAX(WD)) dut (
        .CLK(CLK), .resetl(resetl), .start(start), .startpc_in(startpc_in),
        .endpc(endpc), .expected(expected), .currentpc(core_pc), .dmemout(dmemout),
        .proc_resetl(proc_resetl), .startpc(startpc), .busy(busy), .done(done),
        .pass(pass), .timeout(timeout), .result(result), .cycles(cycles)
    );

    proc_run_monitor #(.WIDTH(W), .RESET_CYCLES(3), .WATCHDOG_MAX(WD)) dut3 (
        .CLK(CLK), .resetl(resetl), .start(start3), .startpc_in(zero_w),
        .endpc(zero_w), .expected(zero_w), .currentpc(zero_w), .dmemout(zero_w),
        .proc_resetl(proc_resetl3), .startpc(startpc3), .busy(busy3), .done(done3),
        .pass(pass3), .timeout(timeout3), .result(result3), .cycles(cycles3)
    );

    // Processor stand-in: PC loads startpc while held in reset, then steps.
    always @(posedge CLK) begin
        if (!proc_resetl) core_pc <= startpc;
        else              core_pc <= core_pc + pc_step;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Outcome model: the PC seen on RUN edge k (k from 0) is sp + st*k; the
    // first edge where it reaches ep ends the run with cycles = k+1, provided
    // that happens within WD edges; otherwise the watchdog ends it at WD.
    function automatic void model(input logic [W-1:0] sp, input logic [W-1:0] ep,
                                  input logic [W-1:0] st, output int cyc, output bit to);
        to  = 1'b1;
        cyc = WD;
        for (int k = 0; k < WD; k++) begin
            if (sp + st * W'(k) >= ep) begin
                cyc = k + 1;
                to  = 1'b0;
                break;
            end
        end
    endfunction

    // One complete run from start to done, with optional start pokes mid-run.
    task automatic run(input string nm, input logic [W-1:0] sp, input logic [W-1:0] ep,
                       input logic [W-1:0] ex, input logic [W-1:0] st,
                       input logic [W-1:0] dm, input bit poke);
        int  cyc, edges, low;
        bit  to;
        logic [W-1:0] exp_res;
        model(sp, ep, st, cyc, to);
        exp_res = to ? '0 : dm;
        startpc_in = sp; endpc = ep; expected = ex; pc_step = st; dmemout = dm;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({nm, ".accept_busy"}, W'(busy), W'(1));
        chk({nm, ".accept_done_clr"}, W'({done, pass, timeout}), W'(0));
        chk({nm, ".accept_result_clr"}, result, '0);
        chk({nm, ".accept_cycles_clr"}, W'(cycles), W'(0));
        chk({nm, ".startpc"}, startpc, sp);
        edges = 0;
        low   = 0;
        while (edges < 700) begin
            if (proc_resetl == 1'b0) low++;
            if (done) break;
            if (poke && edges == 4) begin
                chk({nm, ".poke_busy"}, W'(busy), W'(1));
                start = 1'b1; startpc_in = ~sp; endpc = '0;
            end
            if (poke && edges == 5) begin
                start = 1'b0; startpc_in = sp; endpc = ep;
                chk({nm, ".poke_startpc_held"}, startpc, sp);
            end
            tick();
            edges++;
        end
        chk({nm, ".done"}, W'(done), W'(1));
        chk({nm, ".busy_end"}, W'(busy), W'(0));
        chk({nm, ".reset_low_cycles"}, W'(low), W'(1));
        chk({nm, ".latency"}, W'(edges), W'(to ? 1 + WD : 1 + cyc + 1));
        chk({nm, ".cycles"}, W'(cycles), W'(cyc));
        chk({nm, ".timeout"}, W'(timeout), W'(to));
        chk({nm, ".pass"}, W'(pass), W'(!to && dm == ex));
        chk({nm, ".result"}, result, exp_res);
        $display("run %s sp=%0h ep=%0h step=%0d dm=%0h ex=%0h -> cycles=%0d timeout=%0b pass=%0b",
                 nm, sp, ep, st, dm, ex, cycles, timeout, pass);
    endtask

    initial begin
        int low3, e3;
        logic [W-1:0] sp, ep, ex;
        resetl = 1'b0; start = 1'b0; start3 = 1'b0; zero_w = '0;
        startpc_in = '0; endpc = '0; expected = '0; dmemout = '0; pc_step = 64'd4;
        #1;
        // Reset values, no clock edge yet.
        chk("rst.proc_resetl", W'(proc_resetl), W'(0));
        chk("rst.flags", W'({busy, done, pass, timeout}), W'(0));
        chk("rst.startpc", startpc, '0);
        chk("rst.result", result, '0);
        chk("rst.cycles", W'(cycles), W'(0));
        tick(); tick();
        resetl = 1'b1;
        tick(); tick();
        chk("idle.proc_resetl", W'(proc_resetl), W'(1));
        chk("idle.busy", W'(busy), W'(0));

        // Directed runs.
        run("pass",   64'h0, 64'h34, 64'hF, 64'd4, 64'hF, 1'b0);
        run("fail",   64'h0, 64'h34, 64'hF, 64'd4, 64'hE, 1'b0);
        run("stuck",  64'h10, 64'h34, 64'hF, 64'd0, 64'hF, 1'b0);
        run("wd_tie", 64'h0, 64'd1016, 64'h5, 64'd4, 64'h5, 1'b0);
        run("wd_one", 64'h0, 64'd1020, 64'h5, 64'd4, 64'h5, 1'b0);
        run("poke",   64'h100, 64'h300, 64'h77, 64'd4, 64'h77, 1'b1);

        // Randomized runs.
        for (int i = 0; i < 8; i++) begin
            sp = W'($urandom_range(100, 4000)) & ~64'h3;
            ep = sp + W'($urandom_range(0, 1100)) - 64'd40;
            ex = {$urandom, $urandom};
            run("rand", sp, ep, ex, W'(4 * $urandom_range(1, 2)),
                ($urandom_range(0, 1) == 1) ? ex : ex ^ W'($urandom_range(1, 255)), 1'b0);
        end

        // Three-cycle reset hold on the second build.
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        low3 = 0; e3 = 0;
        while (!done3 && e3 < 50) begin
            if (proc_resetl3 == 1'b0) low3++;
            tick();
            e3++;
        end
        chk("rc3.reset_low_cycles", W'(low3), W'(3));
        chk("rc3.done", W'(done3), W'(1));
        chk("rc3.pass", W'(pass3), W'(1));
        chk("rc3.cycles", W'(cycles3), W'(1));
        $display("run rc3 low=%0d cycles=%0d pass=%0b", low3, cycles3, pass3);

        // Asynchronous abort in the middle of a run.
        startpc_in = 64'h0; endpc = 64'h400; expected = 64'h1; pc_step = 64'd4; dmemout = 64'h1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("abort.busy_before", W'(busy), W'(1));
        #2 resetl = 1'b0;
        #1;
        chk("abort.proc_resetl", W'(proc_resetl), W'(0));
        chk("abort.flags", W'({busy, done, pass, timeout}), W'(0));
        chk("abort.cycles", W'(cycles), W'(0));
        chk("abort.startpc", startpc, '0);
        tick();
        resetl = 1'b1;
        repeat (300) tick();
        chk("abort.no_done", W'({busy, done}), W'(0));
        chk("abort.idle_proc_resetl", W'(proc_resetl), W'(1));
        $display("run abort busy=%0b done=%0b proc_resetl=%0b", busy, done, proc_resetl);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
